serial_add_ctrl: RTL and testbench

Bit-serial add/subtract controller that drives a single `fulladder` cell over WIDTH clock cycles, LSB first, to produce a WIDTH-bit result. It is the area-minimal arithmetic path of the ALU. It accepts one operation through a start/busy/done handshake and holds the result until the next operation is accepted. A carry flop and operand shift registers turn the combinational cell into a sequential adder.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/fulladder.sv | 22 ++
 rtl/serial_add_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU arithmetic paths. Holds the
//                serial controller state encoding, the operation encoding and
//                the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width of the serial arithmetic path.
    localparam int c_default_width = 8;

    // Serial controller state encoding.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Operation encoding carried on op_sub.
    localparam logic c_op_add = 1'b0;
    localparam logic c_op_sub = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder
//  Description : Single-bit combinational full adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module fulladder (
    input  logic in_a,
    input  logic in_b,
    input  logic in_c,
    output logic sum_out,
    output logic c_out
);

    // Sum and carry of the three input bits.
    always_comb begin
        sum_out = in_a ^ in_b ^ in_c;
        c_out   = (in_a & in_b) | (in_c & (in_a ^ in_b));
    end

endmodule : fulladder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial add/subtract controller. Streams the operands LSB
//                first through one fulladder cell over WIDTH cycles, using a
//                carry flop and operand shift registers, and reports the
//                result with carry-out and signed overflow through a
//                start/busy/done handshake.
//                Build option SERIAL_SUB_EN: when defined, op_sub selects
//                subtraction (B inverted, carry-in 1); when undefined every
//                operation is an add and op_sub is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf_out
);

    localparam int               c_cnt_w   = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum_out;
    logic               r_c_out;
    logic               r_ovf_out;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin;
    logic               w_fa_sum;
    logic               w_fa_cout;
    logic               w_last_bit;

`ifdef SERIAL_SUB_EN
    logic w_sub;

    // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
    assign w_sub    = (op_sub == c_op_sub);
    assign w_b_load = w_sub ? ~in_b : in_b;
    assign w_cin    = w_sub;
`else
    logic w_unused_op_sub;

    // Add-only build: B loads unmodified and the carry always starts at 0.
    assign w_b_load        = in_b;
    assign w_cin           = c_op_add;
    assign w_unused_op_sub = op_sub ^ c_op_sub;
`endif

    assign w_last_bit = (r_cnt == c_cnt_last);

    // The single arithmetic cell sees the current LSBs and the carry flop.
    fulladder u_fulladder (
        .in_a    (r_a[0]),
        .in_b    (r_b[0]),
        .in_c    (r_carry),
        .sum_out (w_fa_sum),
        .c_out   (w_fa_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, run WIDTH bit-cycles, one DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start)      w_state_nxt = c_st_run;
            c_st_run:  if (w_last_bit) w_state_nxt = c_st_done;
            c_st_done:                 w_state_nxt = c_st_idle;
            default:                   w_state_nxt = c_st_idle;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy = (r_state != c_st_idle);
        done = (r_state == c_st_done);
    end

    // Operand/result shifting, carry tracking and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum_out <= '0;
            r_c_out   <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a     <= in_a;
                        r_b     <= w_b_load;
                        r_carry <= w_cin;
                        r_cnt   <= '0;
                        r_res   <= '0;
                    end
                end
                c_st_run: begin
                    r_res   <= {w_fa_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + c_cnt_one;
                    // On the MSB cycle the carry flop still holds the carry
                    // into the MSB, so overflow is that XOR the carry out.
                    if (w_last_bit) begin
                        r_sum_out <= {w_fa_sum, r_res[WIDTH-1:1]};
                        r_c_out   <= w_fa_cout;
                        r_ovf_out <= r_carry ^ w_fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum_out = r_sum_out;
    assign c_out   = r_c_out;
    assign ovf_out = r_ovf_out;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl. Directed and random
//                add/subtract operations compared against an arithmetic
//                reference model, plus handshake, ignore and reset checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 8;

`ifdef SERIAL_SUB_EN
    localparam bit c_sub_en = 1'b1;
`else
    localparam bit c_sub_en = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         c_out;
    logic         ovf_out;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_sub  (op_sub),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .c_out   (c_out),
        .ovf_out (ovf_out)
    );

    always #5 clk = ~clk;

    // Count done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit sub, output logic [W-1:0] s,
                                  output logic c, output logic v);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub && c_sub_en) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            c  = (ur >= (2 ** W));
        end
        s = ur[W-1:0];
        v = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    endfunction

    // One complete operation from accept to return to IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sub, input string tag);
        logic [W-1:0] es;
        logic         ec, ev;
        int           lat;
        model(a, b, sub, es, ec, ev);
        start  = 1'b1;
        in_a   = a;
        in_b   = b;
        op_sub = sub;
        tick();
        start  = 1'b0;
        in_a   = W'($urandom);
        in_b   = W'($urandom);
        op_sub = 1'($urandom);
        check({tag, ":busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 2 * W) begin
            tick();
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(W));
        check({tag, ":sum"}, 32'(sum_out), 32'(es));
        check({tag, ":c"}, 32'(c_out), 32'(ec));
        check({tag, ":ovf"}, 32'(ovf_out), 32'(ev));
        tick();
        check({tag, ":done_low"}, 32'(done), 32'd0);
        check({tag, ":idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] es;
        logic         ec, ev;
        int           cyc;
        int           d0;

        rst    = 1'b1;
        start  = 1'b1;
        op_sub = 1'b0;
        in_a   = 8'h12;
        in_b   = 8'h34;
        repeat (3) tick();
        start = 1'b0;
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:sum", 32'(sum_out), 32'd0);
        check("reset:c", 32'(c_out), 32'd0);
        check("reset:ovf", 32'(ovf_out), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_start:busy", 32'(busy), 32'd0);

        // Directed cases.
        run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
        check("add_7f_01:lit_sum", 32'(sum_out), 32'h80);
        check("add_7f_01:lit_c", 32'(c_out), 32'd0);
        check("add_7f_01:lit_ovf", 32'(ovf_out), 32'd1);
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        check("add_ff_01:lit_sum", 32'(sum_out), 32'h00);
        check("add_ff_01:lit_c", 32'(c_out), 32'd1);
        check("add_ff_01:lit_ovf", 32'(ovf_out), 32'd0);
        run_op(8'h05, 8'h07, 1'b1, "sub_05_07");
`ifdef SERIAL_SUB_EN
        check("sub_05_07:lit_sum", 32'(sum_out), 32'hFE);
        check("sub_05_07:lit_c", 32'(c_out), 32'd0);
        check("sub_05_07:lit_ovf", 32'(ovf_out), 32'd0);
`endif
        run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
`ifdef SERIAL_SUB_EN
        check("sub_80_01:lit_sum", 32'(sum_out), 32'h7F);
        check("sub_80_01:lit_c", 32'(c_out), 32'd1);
        check("sub_80_01:lit_ovf", 32'(ovf_out), 32'd1);
`endif

        // start pulses during RUN and DONE must be ignored.
        d0 = done_cnt;
        model(8'h3C, 8'h11, 1'b0, es, ec, ev);
        start  = 1'b1;
        op_sub = 1'b0;
        in_a   = 8'h3C;
        in_b   = 8'h11;
        tick();
        cyc = 0;
        while (done !== 1'b1 && cyc < 2 * W) begin
            start = (cyc == 3);
            in_a  = 8'hFF;
            in_b  = 8'hFF;
            tick();
            cyc++;
        end
        check("ignore:latency", 32'(cyc), 32'(W));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore:busy_after_done", 32'(busy), 32'd0);
        check("ignore:sum", 32'(sum_out), 32'(es));
        repeat (3) tick();
        check("ignore:still_idle", 32'(busy), 32'd0);
        check("ignore:sum_held", 32'(sum_out), 32'(es));
        check("ignore:done_count", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of an operation.
        start  = 1'b1;
        op_sub = 1'b0;
        in_a   = 8'hAA;
        in_b   = 8'h55;
        tick();
        start = 1'b0;
        repeat (4) tick();
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:done", 32'(done), 32'd0);
        check("midrst:sum", 32'(sum_out), 32'd0);
        check("midrst:c", 32'(c_out), 32'd0);
        check("midrst:ovf", 32'(ovf_out), 32'd0);
        repeat (W + 2) tick();
        check("midrst:no_done", 32'(done_cnt - d0), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, "after_rst");
        check("after_rst:lit_sum", 32'(sum_out), 32'h02);

        // Randomised operations back to back.
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
